// File: rtl/nios_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios_pio_pkg
// Description : Register map and STATUS layout shared by the output PIO.
// Revision    : 1.0
// ============================================================================
package nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_OUTSET    = 3'd2;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd3;
    localparam logic [2:0] ADDR_PULSE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int STATUS_ACTIVE_BIT = 0;
    localparam int STATUS_CNT_LSB    = 1;

endpackage
`default_nettype wire

// File: rtl/nios_pio_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : nios_pio_pulse_timer
// Description : Loadable down-counter timing the auto-clearing pulse.
// Revision    : 1.0
// ============================================================================
module nios_pio_pulse_timer
    import nios_pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             cancel,
    output logic             active,
    output logic             expire,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (cancel) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (load) begin
            // A zero length still produces a one-cycle pulse.
            cnt_d    = (load_val == '0) ? CNT_W'(1) : load_val;
            active_d = 1'b1;
        end else if (active_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign cnt    = cnt_q;
    assign expire = active_q && (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/nios_pio_out_ext.sv
`default_nettype none
// ============================================================================
// Module      : nios_pio_out_ext
// Description : Avalon-MM output PIO with atomic set/clear and timed pulses.
// Revision    : 1.0
// ============================================================================
module nios_pio_out_ext
    import nios_pio_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               CNT_W         = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter logic [CNT_W-1:0] PULSE_DEFAULT = CNT_W'(1000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_active
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic             tmr_load, tmr_cancel, tmr_active, tmr_expire;
    logic [CNT_W-1:0] tmr_cnt;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_comb begin
        data_d     = data_q;
        mask_d     = mask_q;
        len_d      = len_q;
        tmr_load   = 1'b0;
        tmr_cancel = 1'b0;
        // Expiry is applied first so that later bus writes override it.
        if (tmr_expire) begin
            data_d = data_q & ~mask_q;
            mask_d = '0;
        end
        if (wr_en) begin
            case (address)
                ADDR_DATA: begin
                    data_d     = wd;
                    mask_d     = '0;
                    tmr_cancel = 1'b1;
                end
                ADDR_PULSE_LEN: len_d = writedata[CNT_W-1:0];
                ADDR_OUTSET:    data_d = data_d | wd;
                ADDR_OUTCLEAR: begin
                    data_d = data_d & ~wd;
                    mask_d = mask_d & ~wd;
                end
                ADDR_PULSE: begin
                    // A restart discards any coincident expiry.
                    if (wd != '0) begin
                        data_d   = data_q | wd;
                        mask_d   = mask_q | wd;
                        tmr_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            len_q  <= PULSE_DEFAULT;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            len_q  <= len_d;
        end
    end

    nios_pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (len_q),
        .cancel   (tmr_cancel),
        .active   (tmr_active),
        .expire   (tmr_expire),
        .cnt      (tmr_cnt)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_q);
            ADDR_PULSE_LEN: readdata = 32'(len_q);
            ADDR_STATUS:    readdata = 32'({tmr_cnt, tmr_active});
            default:        readdata = '0;
        endcase
    end

    assign out_port     = data_q;
    assign pulse_active = tmr_active;

endmodule
`default_nettype wire

// File: tb/tb_nios_pio_out_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_pio_out_ext
// Description : Directed plus randomized bench against a deadline-based model.
// Revision    : 1.0
// ============================================================================
module tb_nios_pio_out_ext;
    import nios_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_active;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a pulse is a deadline edge number rather than a counter.
    longint     n_edge = 0;
    logic [7:0] m_data;
    logic [7:0] m_mask;
    int         m_len;
    bit         m_active;
    longint     m_deadline;

    nios_pio_out_ext #(
        .WIDTH         (8),
        .CNT_W         (16),
        .RESET_VALUE   (8'hA5),
        .PULSE_DEFAULT (16'd1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .out_port     (out_port),
        .pulse_active (pulse_active)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_data     = 8'hA5;
        m_mask     = 8'h00;
        m_len      = 1000;
        m_active   = 1'b0;
        m_deadline = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        longint remaining;
        remaining = m_active ? (m_deadline - n_edge) : 0;
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd1:    return 32'(m_len);
            3'd5:    return 32'(remaining * 2 + (m_active ? 1 : 0));
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input logic [2:0] a, input logic [31:0] d, input bit wr);
        logic [7:0] nd, nm, w;
        bit         na;
        w  = d[7:0];
        nd = m_data;
        nm = m_mask;
        na = m_active;
        if (m_active && n_edge == m_deadline) begin
            nd = nd & ~m_mask;
            nm = 8'h00;
            na = 1'b0;
        end
        if (wr) begin
            case (a)
                3'd0: begin nd = w; nm = 8'h00; na = 1'b0; end
                3'd1: m_len = int'(d[15:0]);
                3'd2: nd = nd | w;
                3'd3: begin nd = nd & ~w; nm = nm & ~w; end
                3'd4: if (w != 8'h00) begin
                    nd = m_data | w;
                    nm = m_mask | w;
                    na = 1'b1;
                    m_deadline = n_edge + ((m_len == 0) ? 1 : m_len);
                end
                default: ;
            endcase
        end
        m_data   = nd;
        m_mask   = nm;
        m_active = na;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_cycle(input logic [2:0] a, input logic [31:0] d, input bit cs, input bit wn);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = wn;
        #1;
        chk($sformatf("readdata@%0d", a), readdata, model_read(a));
        @(posedge clk);
        n_edge++;
        model_edge(a, d, cs & ~wn);
        #1;
        chk("out_port", {24'd0, out_port}, {24'd0, m_data});
        chk("pulse_active", {31'd0, pulse_active}, {31'd0, m_active});
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        do_cycle(a, d, 1'b1, 1'b0);
    endtask

    task automatic idle(input logic [2:0] a);
        do_cycle(a, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] r, d;
        logic [2:0]  a;
        bit          cs, wn;

        reset = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("reset out_port", {24'd0, out_port}, 32'h0000_00A5);
        chk("reset pulse_active", {31'd0, pulse_active}, 32'd0);
        idle(3'd5);
        idle(3'd1);

        // DATA / OUTSET / OUTCLEAR
        wr(3'd0, 32'h0000_000F);
        chk("data write", {24'd0, out_port}, 32'h0F);
        wr(3'd2, 32'hFFFF_FF30);
        chk("outset", {24'd0, out_port}, 32'h3F);
        wr(3'd3, 32'h0000_0003);
        chk("outclear", {24'd0, out_port}, 32'h3C);
        idle(3'd2);
        idle(3'd3);

        // Length-4 pulse
        wr(3'd1, 32'd4);
        wr(3'd0, 32'd0);
        wr(3'd4, 32'h81);
        chk("pulse E", {24'd0, out_port}, 32'h81);
        repeat (3) idle(3'd5);
        chk("pulse E+3", {24'd0, out_port}, 32'h81);
        idle(3'd5);
        chk("pulse E+4", {24'd0, out_port}, 32'h00);
        chk("pulse E+4 active", {31'd0, pulse_active}, 32'd0);

        // Zero length gives one cycle; overlapping pulses clear together
        wr(3'd1, 32'd0);
        wr(3'd4, 32'h01);
        chk("len0 on", {24'd0, out_port}, 32'h01);
        idle(3'd5);
        chk("len0 off", {24'd0, out_port}, 32'h00);
        wr(3'd1, 32'd5);
        wr(3'd4, 32'h01);
        idle(3'd5);
        wr(3'd4, 32'h02);
        repeat (4) idle(3'd5);
        chk("overlap E2+4", {24'd0, out_port}, 32'h03);
        idle(3'd5);
        chk("overlap E2+5", {24'd0, out_port}, 32'h00);

        // Expiry-edge collisions
        wr(3'd1, 32'd3);
        wr(3'd4, 32'h01);
        idle(3'd5);
        idle(3'd5);
        wr(3'd2, 32'h01);
        chk("expiry+outset", {24'd0, out_port}, 32'h01);
        chk("expiry+outset active", {31'd0, pulse_active}, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd4, 32'h01);
        idle(3'd5);
        idle(3'd5);
        wr(3'd0, 32'h10);
        chk("expiry+data", {24'd0, out_port}, 32'h10);
        wr(3'd4, 32'h01);
        idle(3'd5);
        idle(3'd5);
        wr(3'd4, 32'h04);
        chk("expiry+pulse", {24'd0, out_port}, 32'h15);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom;
            a  = r[2:0];
            cs = (r[5:3] != 3'd0);
            wn = r[6];
            d  = $urandom;
            if (a == 3'd1) begin
                d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            end else if (a == 3'd0 && r[9:7] != 3'd0) begin
                cs = 1'b0;
            end else if (a == 3'd4 && r[12:10] == 3'd0) begin
                d = d & 32'hFFFF_FF00;
            end
            do_cycle(a, d, cs, wn);
        end

        // Asynchronous reset mid-pulse
        wr(3'd1, 32'd600);
        wr(3'd0, 32'd0);
        wr(3'd4, 32'h5A);
        repeat (100) idle(3'd5);
        #2 reset = 1'b1;
        #1;
        chk("async reset out_port", {24'd0, out_port}, 32'h0000_00A5);
        chk("async reset active", {31'd0, pulse_active}, 32'd0);
        model_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        repeat (520) idle(3'd5);
        chk("no delayed clear", {24'd0, out_port}, 32'h0000_00A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
